alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station feeding the integer ALU in the out-of-order core.
- Buffers dispatched ALU ops whose operands may still be pending on ROB tags.
- Snoops both CDB buses (ALU and LSB results) to wake up pending operands.
- Issues at most one ready op per cycle to the ALU's valid/opr1/opr2/rob_id/op inputs.

Parameters:
- RS_SIZE, 8, number of entries; power of two.
- RS_SIZE_WIDTH, 3, log2(RS_SIZE).
- ROB_SIZE_WIDTH, 4, ROB tag width; must equal `ROB_SIZE_WIDTH.
- CALC_OP_L1_NUM_WIDTH, 4, ALU level-1 opcode width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global ready; low = stall.
- need_flush_in  in  1  misprediction flush.
- dispatch_valid_in  in  1  new op this cycle.
- vj_in, vk_in  in  32  operand values, meaningful when the matching q*_valid_in is 0.
- qj_valid_in, qk_valid_in  in  1  operand pending on a ROB tag.
- qj_in, qk_in  in  ROB_SIZE_WIDTH  producer ROB tags.
- rob_id_in  in  ROB_SIZE_WIDTH  destination tag.
- op_L1_in  in  CALC_OP_L1_NUM_WIDTH  ALU level-1 op.
- op_L2_in  in  1  ALU level-2 op (add/sub, srl/sra).
- full_out  out  1  no free entry.
- cdb_alu_ready_in  in  1  ALU broadcast valid.
- cdb_alu_value_in  in  32  ALU broadcast value.
- cdb_alu_rob_id_in  in  ROB_SIZE_WIDTH  ALU broadcast tag.
- cdb_lsb_ready_in  in  1  LSB broadcast valid.
- cdb_lsb_value_in  in  32  LSB broadcast value.
- cdb_lsb_rob_id_in  in  ROB_SIZE_WIDTH  LSB broadcast tag.
- alu_valid_out  out  1  issue strobe to the ALU.
- alu_opr1_out, alu_opr2_out  out  32  issued operands.
- alu_rob_id_out  out  ROB_SIZE_WIDTH  issued tag.
- alu_op_L1_out  out  CALC_OP_L1_NUM_WIDTH  issued level-1 op.
- alu_op_L2_out  out  1  issued level-2 op.

Behaviour:
- Per-entry state: busy, vj, vk, qj_valid, qk_valid, qj, qk, rob_id, op_L1, op_L2.

Reset and stall/flush:
- On rst_in: all busy=0; all outputs 0.
- rdy_in=0: all entry state holds; alu_valid_out<=0; dispatch and CDB are ignored.
- need_flush_in=1 (rdy_in=1): all busy<=0; alu_valid_out<=0; same-cycle dispatch is dropped. Flush takes priority over everything.

full_out:
- Combinational; equals 1 when all RS_SIZE entries are busy.
- A dispatch while full_out=1 is ignored. A slot freed by issue in the same cycle is not reused until the next cycle.

Dispatch:
- Allocates the lowest-index free entry.
- Same-cycle CDB bypass: if q*_valid_in=1 and a CDB bus is ready with a matching tag, the entry stores the broadcast value with q*_valid=0.

Wakeup:
- Every busy entry with q*_valid=1 compares against both CDB buses each cycle. On a match, v* <= value and q*_valid <= 0.
- Both buses never carry the same tag simultaneously.

Issue:
- Eligible entry: busy=1 and qj_valid=0 and qk_valid=0, evaluated on registered state only.
- The lowest-index eligible entry is chosen.
- On the edge: alu_* outputs <= entry fields, alu_valid_out<=1, entry busy<=0.
- No eligible entry: alu_valid_out<=0; other alu_* outputs hold.
- alu_valid_out is a 1-cycle pulse per issue; the ALU has no backpressure.

Latency:
- Dispatch with ready operands at edge k -> alu_valid_out high after edge k+1.
- Wakeup at edge k -> issue at edge k+1.
- Occupancy changes by dispatch and issue in the same cycle are independent (at most +1 and -1).

Test Plan:
- Reset, then dispatch vj=5, vk=7, no pending, rob_id=3, op ADD -> one cycle later alu_valid_out=1, opr1=5, opr2=7, rob_id=3; next cycle alu_valid_out=0, full_out=0.
- Dispatch qj_valid=1, qj=2, vk=1; two cycles later cdb_lsb rob_id=2, value=0x100 -> issue on the following edge with opr1=0x100, opr2=1; no issue before the wakeup.
- Dispatch qj=4 in the same cycle cdb_alu reports rob_id=4, value=9 -> stored ready; issued next cycle with opr1=9.
- Fill 8 pending entries -> full_out=1; a 9th dispatch is ignored; wake entries 5 and 2 together -> entry 2 issues first, entry 5 on the next cycle.
- With 3 busy entries, assert need_flush_in together with a dispatch -> all entries cleared, alu_valid_out=0, full_out=0, no later issue.
- Hold rdy_in=0 for 3 cycles with ready entries present -> no issue, alu_valid_out=0, state kept; issue resumes the cycle after rdy_in returns high.

Source files
------------

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops, wakes pending operands from
// both CDB buses and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE              = 8,
  parameter int unsigned RS_SIZE_WIDTH        = 3,
  parameter int unsigned ROB_SIZE_WIDTH       = 4,
  parameter int unsigned CALC_OP_L1_NUM_WIDTH = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            need_flush_in,

  input  logic                            dispatch_valid_in,
  input  logic [31:0]                     vj_in,
  input  logic [31:0]                     vk_in,
  input  logic                            qj_valid_in,
  input  logic                            qk_valid_in,
  input  logic [ROB_SIZE_WIDTH-1:0]       qj_in,
  input  logic [ROB_SIZE_WIDTH-1:0]       qk_in,
  input  logic [ROB_SIZE_WIDTH-1:0]       rob_id_in,
  input  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_L1_in,
  input  logic                            op_L2_in,
  output logic                            full_out,

  input  logic                            cdb_alu_ready_in,
  input  logic [31:0]                     cdb_alu_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0]       cdb_alu_rob_id_in,
  input  logic                            cdb_lsb_ready_in,
  input  logic [31:0]                     cdb_lsb_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0]       cdb_lsb_rob_id_in,

  output logic                            alu_valid_out,
  output logic [31:0]                     alu_opr1_out,
  output logic [31:0]                     alu_opr2_out,
  output logic [ROB_SIZE_WIDTH-1:0]       alu_rob_id_out,
  output logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
  output logic                            alu_op_L2_out
);

  logic [RS_SIZE-1:0]              busy_q, busy_d;
  logic [RS_SIZE-1:0]              qj_valid_q, qj_valid_d;
  logic [RS_SIZE-1:0]              qk_valid_q, qk_valid_d;
  logic [RS_SIZE-1:0]              op_l2_q, op_l2_d;
  logic [31:0]                     vj_q [RS_SIZE];
  logic [31:0]                     vj_d [RS_SIZE];
  logic [31:0]                     vk_q [RS_SIZE];
  logic [31:0]                     vk_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       qj_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       qj_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       qk_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       qk_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       rob_id_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       rob_id_d [RS_SIZE];
  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1_q [RS_SIZE];
  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1_d [RS_SIZE];

  logic                            alu_valid_q, alu_valid_d;
  logic [31:0]                     alu_opr1_q, alu_opr1_d;
  logic [31:0]                     alu_opr2_q, alu_opr2_d;
  logic [ROB_SIZE_WIDTH-1:0]       alu_rob_id_q, alu_rob_id_d;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_l1_q, alu_op_l1_d;
  logic                            alu_op_l2_q, alu_op_l2_d;

  logic [RS_SIZE-1:0]              eligible;
  logic                            issue_found, free_found;
  logic [RS_SIZE_WIDTH-1:0]        issue_idx, free_idx;
  logic [31:0]                     disp_vj, disp_vk;
  logic                            disp_qj_valid, disp_qk_valid;

  assign eligible = busy_q & ~qj_valid_q & ~qk_valid_q;
  assign full_out = &busy_q;

  // Both selections look at registered state only, so a slot freed by issue this cycle is not
  // reallocated until the next one.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_SIZE_WIDTH'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // Same-cycle CDB bypass for operands arriving with dispatch.
  always_comb begin
    disp_vj       = vj_in;
    disp_qj_valid = qj_valid_in;
    disp_vk       = vk_in;
    disp_qk_valid = qk_valid_in;
    if (qj_valid_in) begin
      if (cdb_alu_ready_in && (cdb_alu_rob_id_in == qj_in)) begin
        disp_vj       = cdb_alu_value_in;
        disp_qj_valid = 1'b0;
      end else if (cdb_lsb_ready_in && (cdb_lsb_rob_id_in == qj_in)) begin
        disp_vj       = cdb_lsb_value_in;
        disp_qj_valid = 1'b0;
      end
    end
    if (qk_valid_in) begin
      if (cdb_alu_ready_in && (cdb_alu_rob_id_in == qk_in)) begin
        disp_vk       = cdb_alu_value_in;
        disp_qk_valid = 1'b0;
      end else if (cdb_lsb_ready_in && (cdb_lsb_rob_id_in == qk_in)) begin
        disp_vk       = cdb_lsb_value_in;
        disp_qk_valid = 1'b0;
      end
    end
  end

  always_comb begin
    busy_d       = busy_q;
    qj_valid_d   = qj_valid_q;
    qk_valid_d   = qk_valid_q;
    op_l2_d      = op_l2_q;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      vj_d[i]     = vj_q[i];
      vk_d[i]     = vk_q[i];
      qj_d[i]     = qj_q[i];
      qk_d[i]     = qk_q[i];
      rob_id_d[i] = rob_id_q[i];
      op_l1_d[i]  = op_l1_q[i];
    end
    alu_valid_d  = 1'b0;
    alu_opr1_d   = alu_opr1_q;
    alu_opr2_d   = alu_opr2_q;
    alu_rob_id_d = alu_rob_id_q;
    alu_op_l1_d  = alu_op_l1_q;
    alu_op_l2_d  = alu_op_l2_q;

    if (rdy_in) begin
      if (need_flush_in) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy_q[i] && qj_valid_q[i]) begin
            if (cdb_alu_ready_in && (cdb_alu_rob_id_in == qj_q[i])) begin
              vj_d[i]       = cdb_alu_value_in;
              qj_valid_d[i] = 1'b0;
            end else if (cdb_lsb_ready_in && (cdb_lsb_rob_id_in == qj_q[i])) begin
              vj_d[i]       = cdb_lsb_value_in;
              qj_valid_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && qk_valid_q[i]) begin
            if (cdb_alu_ready_in && (cdb_alu_rob_id_in == qk_q[i])) begin
              vk_d[i]       = cdb_alu_value_in;
              qk_valid_d[i] = 1'b0;
            end else if (cdb_lsb_ready_in && (cdb_lsb_rob_id_in == qk_q[i])) begin
              vk_d[i]       = cdb_lsb_value_in;
              qk_valid_d[i] = 1'b0;
            end
          end
        end

        if (issue_found) begin
          busy_d[issue_idx] = 1'b0;
          alu_valid_d       = 1'b1;
          alu_opr1_d        = vj_q[issue_idx];
          alu_opr2_d        = vk_q[issue_idx];
          alu_rob_id_d      = rob_id_q[issue_idx];
          alu_op_l1_d       = op_l1_q[issue_idx];
          alu_op_l2_d       = op_l2_q[issue_idx];
        end

        if (dispatch_valid_in && free_found) begin
          busy_d[free_idx]     = 1'b1;
          vj_d[free_idx]       = disp_vj;
          vk_d[free_idx]       = disp_vk;
          qj_valid_d[free_idx] = disp_qj_valid;
          qk_valid_d[free_idx] = disp_qk_valid;
          qj_d[free_idx]       = qj_in;
          qk_d[free_idx]       = qk_in;
          rob_id_d[free_idx]   = rob_id_in;
          op_l1_d[free_idx]    = op_L1_in;
          op_l2_d[free_idx]    = op_L2_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      qj_valid_q   <= '0;
      qk_valid_q   <= '0;
      op_l2_q      <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        rob_id_q[i] <= '0;
        op_l1_q[i]  <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_opr1_q   <= '0;
      alu_opr2_q   <= '0;
      alu_rob_id_q <= '0;
      alu_op_l1_q  <= '0;
      alu_op_l2_q  <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      qj_valid_q   <= qj_valid_d;
      qk_valid_q   <= qk_valid_d;
      op_l2_q      <= op_l2_d;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        vj_q[i]     <= vj_d[i];
        vk_q[i]     <= vk_d[i];
        qj_q[i]     <= qj_d[i];
        qk_q[i]     <= qk_d[i];
        rob_id_q[i] <= rob_id_d[i];
        op_l1_q[i]  <= op_l1_d[i];
      end
      alu_valid_q  <= alu_valid_d;
      alu_opr1_q   <= alu_opr1_d;
      alu_opr2_q   <= alu_opr2_d;
      alu_rob_id_q <= alu_rob_id_d;
      alu_op_l1_q  <= alu_op_l1_d;
      alu_op_l2_q  <= alu_op_l2_d;
    end
  end

  assign alu_valid_out  = alu_valid_q;
  assign alu_opr1_out   = alu_opr1_q;
  assign alu_opr2_out   = alu_opr2_q;
  assign alu_rob_id_out = alu_rob_id_q;
  assign alu_op_L1_out  = alu_op_l1_q;
  assign alu_op_L2_out  = alu_op_l2_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: a slot-level reference model predicts each issue into a queue, and a
// monitor on the falling edge checks the DUT's issue strobe, payload and full flag against it.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, need_flush_in;
  logic        dispatch_valid_in, qj_valid_in, qk_valid_in, op_L2_in;
  logic [31:0] vj_in, vk_in;
  logic [3:0]  qj_in, qk_in, rob_id_in, op_L1_in;
  logic        full_out;
  logic        cdb_alu_ready_in, cdb_lsb_ready_in;
  logic [31:0] cdb_alu_value_in, cdb_lsb_value_in;
  logic [3:0]  cdb_alu_rob_id_in, cdb_lsb_rob_id_in;
  logic        alu_valid_out, alu_op_L2_out;
  logic [31:0] alu_opr1_out, alu_opr2_out;
  logic [3:0]  alu_rob_id_out, alu_op_L1_out;

  alu_rs dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .need_flush_in     (need_flush_in),
    .dispatch_valid_in (dispatch_valid_in),
    .vj_in             (vj_in),
    .vk_in             (vk_in),
    .qj_valid_in       (qj_valid_in),
    .qk_valid_in       (qk_valid_in),
    .qj_in             (qj_in),
    .qk_in             (qk_in),
    .rob_id_in         (rob_id_in),
    .op_L1_in          (op_L1_in),
    .op_L2_in          (op_L2_in),
    .full_out          (full_out),
    .cdb_alu_ready_in  (cdb_alu_ready_in),
    .cdb_alu_value_in  (cdb_alu_value_in),
    .cdb_alu_rob_id_in (cdb_alu_rob_id_in),
    .cdb_lsb_ready_in  (cdb_lsb_ready_in),
    .cdb_lsb_value_in  (cdb_lsb_value_in),
    .cdb_lsb_rob_id_in (cdb_lsb_rob_id_in),
    .alu_valid_out     (alu_valid_out),
    .alu_opr1_out      (alu_opr1_out),
    .alu_opr2_out      (alu_opr2_out),
    .alu_rob_id_out    (alu_rob_id_out),
    .alu_op_L1_out     (alu_op_L1_out),
    .alu_op_L2_out     (alu_op_L2_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit        busy;
    bit        pj, pk;
    bit [31:0] vj, vk;
    bit [3:0]  qj, qk, rob, op1;
    bit        op2;
  } ent_t;

  typedef struct {
    bit [31:0] a, b;
    bit [3:0]  rob, op1;
    bit        op2;
  } iss_t;

  ent_t  m [8];
  iss_t  exp_q [$];
  int    total = 0;
  int    bad = 0;

  // Returns {still_pending, value} after applying the CDB buses to one operand.
  function automatic bit [32:0] resolve(bit p, bit [3:0] q, bit [31:0] v);
    if (p && cdb_alu_ready_in && cdb_alu_rob_id_in == q) return {1'b0, cdb_alu_value_in};
    if (p && cdb_lsb_ready_in && cdb_lsb_rob_id_in == q) return {1'b0, cdb_lsb_value_in};
    return {p, v};
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: one step per rising edge using the inputs presented for that edge.
  int        pick, free_slot;
  bit [32:0] rj, rk;
  iss_t      it;
  always @(posedge clk_in) begin
    if (rst_in || (rdy_in && need_flush_in)) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
    end else if (rdy_in) begin
      pick = -1;
      free_slot = -1;
      for (int i = 0; i < 8; i++) begin
        if (pick < 0 && m[i].busy && !m[i].pj && !m[i].pk) pick = i;
        if (free_slot < 0 && !m[i].busy) free_slot = i;
      end
      if (pick >= 0) begin
        it.a = m[pick].vj; it.b = m[pick].vk; it.rob = m[pick].rob;
        it.op1 = m[pick].op1; it.op2 = m[pick].op2;
        exp_q.push_back(it);
        m[pick].busy = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy) begin
          rj = resolve(m[i].pj, m[i].qj, m[i].vj);
          rk = resolve(m[i].pk, m[i].qk, m[i].vk);
          {m[i].pj, m[i].vj} = rj;
          {m[i].pk, m[i].vk} = rk;
        end
      end
      if (dispatch_valid_in && free_slot >= 0) begin
        rj = resolve(qj_valid_in, qj_in, vj_in);
        rk = resolve(qk_valid_in, qk_in, vk_in);
        m[free_slot].busy = 1'b1;
        {m[free_slot].pj, m[free_slot].vj} = rj;
        {m[free_slot].pk, m[free_slot].vk} = rk;
        m[free_slot].qj = qj_in; m[free_slot].qk = qk_in;
        m[free_slot].rob = rob_id_in;
        m[free_slot].op1 = op_L1_in; m[free_slot].op2 = op_L2_in;
      end
    end
  end

  // Monitor: every falling edge compares full_out and any issue against the model.
  iss_t e;
  always @(negedge clk_in) begin
    total++;
    if (full_out !== model_full()) begin
      bad++;
      $display("FAIL full_out t=%0t: got %b want %b", $time, full_out, model_full());
    end
    if (alu_valid_out === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue t=%0t: got rob=%0d want no issue", $time, alu_rob_id_out);
      end else begin
        e = exp_q.pop_front();
        if (alu_opr1_out !== e.a || alu_opr2_out !== e.b || alu_rob_id_out !== e.rob ||
            alu_op_L1_out !== e.op1 || alu_op_L2_out !== e.op2) begin
          bad++;
          $display("FAIL issue_payload t=%0t: got %h %h rob=%0d op=%0d/%0d want %h %h rob=%0d op=%0d/%0d",
                   $time, alu_opr1_out, alu_opr2_out, alu_rob_id_out, alu_op_L1_out,
                   alu_op_L2_out, e.a, e.b, e.rob, e.op1, e.op2);
        end
      end
    end else if (alu_valid_out !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL alu_valid_x t=%0t: got %b want 0/1", $time, alu_valid_out);
    end else if (exp_q.size() != 0) begin
      total++;
      bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_issue t=%0t: got no issue want rob=%0d", $time, e.rob);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    dispatch_valid_in = 1'b0;
    cdb_alu_ready_in  = 1'b0;
    cdb_lsb_ready_in  = 1'b0;
    need_flush_in     = 1'b0;
  endtask

  task automatic set_disp(input bit [31:0] vj, input bit [31:0] vk, input bit pj,
                          input bit [3:0] qj, input bit pk, input bit [3:0] qk,
                          input bit [3:0] rob, input bit [3:0] op1, input bit op2);
    dispatch_valid_in = 1'b1;
    vj_in = vj; vk_in = vk; qj_valid_in = pj; qj_in = qj; qk_valid_in = pk; qk_in = qk;
    rob_id_in = rob; op_L1_in = op1; op_L2_in = op2;
  endtask

  task automatic set_alu(input bit [3:0] tag, input bit [31:0] val);
    cdb_alu_ready_in = 1'b1; cdb_alu_rob_id_in = tag; cdb_alu_value_in = val;
  endtask

  task automatic set_lsb(input bit [3:0] tag, input bit [31:0] val);
    cdb_lsb_ready_in = 1'b1; cdb_lsb_rob_id_in = tag; cdb_lsb_value_in = val;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  bit [3:0] ta;
  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0;
    dispatch_valid_in = 1'b0; vj_in = '0; vk_in = '0; qj_valid_in = 1'b0; qk_valid_in = 1'b0;
    qj_in = '0; qk_in = '0; rob_id_in = '0; op_L1_in = '0; op_L2_in = 1'b0;
    cdb_alu_ready_in = 1'b0; cdb_alu_value_in = '0; cdb_alu_rob_id_in = '0;
    cdb_lsb_ready_in = 1'b0; cdb_lsb_value_in = '0; cdb_lsb_rob_id_in = '0;
    ticks(2);
    rst_in = 1'b0;
    total++;
    if (alu_valid_out !== 1'b0 || alu_opr1_out !== 32'd0 || alu_opr2_out !== 32'd0 ||
        alu_rob_id_out !== 4'd0 || alu_op_L1_out !== 4'd0 || alu_op_L2_out !== 1'b0 ||
        full_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b %h %h rob=%0d full=%b want all zero",
               alu_valid_out, alu_opr1_out, alu_opr2_out, alu_rob_id_out, full_out);
    end

    // Ready operands issue one cycle after dispatch.
    set_disp(5, 7, 0, 0, 0, 0, 3, 0, 0); ticks(3);
    // LSB wakeup two cycles after dispatch.
    set_disp(0, 1, 1, 2, 0, 0, 6, 1, 0); ticks(2);
    set_lsb(2, 32'h100); ticks(3);
    // Same-cycle bypass on dispatch.
    set_disp(0, 3, 1, 4, 0, 0, 7, 2, 1); set_alu(4, 9); ticks(3);

    // Fill all entries, entry i waits on tag 8+i; 9th ready dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      set_disp(i, 100 + i, 1, 4'(8 + i), 0, 0, 4'(i), 4'(i), 0); tick();
    end
    set_disp(1, 2, 0, 0, 0, 0, 15, 3, 0); tick();
    set_alu(13, 32'h55); set_lsb(10, 32'h22); ticks(3);
    for (int i = 0; i < 8; i++) begin
      set_alu(4'(8 + i), 32'h1000 + i); tick();
    end
    ticks(4);

    // Flush with a same-cycle dispatch, then late wakeups must issue nothing.
    for (int i = 1; i <= 3; i++) begin
      set_disp(0, 0, 1, 4'(i), 0, 0, 4'(i), 0, 0); tick();
    end
    need_flush_in = 1'b1; set_disp(3, 4, 0, 0, 0, 0, 9, 0, 0); tick();
    set_alu(1, 1); set_lsb(2, 2); tick();
    set_alu(3, 3); ticks(3);

    // Stall with three ready entries; dispatch and CDB ignored while stalled.
    for (int i = 0; i < 3; i++) begin
      set_disp(i, 0, 0, 0, 1, 5, 4'(10 + i), 4'(i), 1); tick();
    end
    set_alu(5, 32'hABCD); tick();
    rdy_in = 1'b0;
    set_disp(7, 7, 0, 0, 0, 0, 14, 1, 0); set_lsb(5, 32'hDEAD); ticks(3);
    rdy_in = 1'b1; ticks(5);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom % 8) != 0;
      need_flush_in = ($urandom % 80) == 0;
      if ($urandom % 2) begin
        set_disp($urandom, $urandom, ($urandom % 2) != 0, 4'($urandom), ($urandom % 3) == 0,
                 4'($urandom), 4'($urandom), 4'($urandom), ($urandom % 2) != 0);
      end
      ta = 4'($urandom);
      if ($urandom % 3 == 0) set_alu(ta, $urandom);
      if ($urandom % 3 == 0) set_lsb(ta + 4'(1 + $urandom % 15), $urandom);
      tick();
    end
    rdy_in = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 16; t++) begin
        set_alu(4'(t), 32'h7000 + t); tick();
      end
    end
    ticks(12);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected issues want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
